// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the hard-wired control sequencer:
// state encodings, opcodes, enable/busSelect bit positions and ALU codes.
package ctrl_sequencer_pkg;

  localparam int OP_W = 5;

  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_INCPC = 5'd14;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd15
  } state_t;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam int EN_ZIN   = 18;
  localparam int EN_YIN   = 19;
  localparam int EN_PCIN  = 20;
  localparam int EN_MDRIN = 21;
  localparam int EN_IRIN  = 24;
  localparam int EN_MARIN = 25;

  localparam int BS_ZLO   = 19;
  localparam int BS_PC    = 20;
  localparam int BS_MDR   = 21;
  localparam int BS_CSIGN = 23;

  // Memory-reference ops all form an effective address via BAout in T3.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic logic has_exec(input opcode_t op);
    return is_mem_op(op) || (op == OP_ADDI);
  endfunction

  function automatic logic is_short_op(input opcode_t op);
    return (op == OP_LDI) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_out_decode.sv
// Moore output decode for the control sequencer: (state, opcode) -> every
// datapath control. T3 decodes the live IR opcode; later steps use op_q.
module ctrl_sequencer_out_decode
  import ctrl_sequencer_pkg::*;
(
  input  state_t      state,
  input  opcode_t     ir_op,
  input  opcode_t     op_q,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        halted
);

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Control_Signals = '0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    Rin             = 1'b0;
    Rout            = 1'b0;
    BAout           = 1'b0;
    MD_Read         = 1'b0;
    ReadRAM         = 1'b0;
    WriteRAM        = 1'b0;
    halted          = 1'b0;

    case (state)
      ST_T0: begin
        busSelect[BS_PC] = 1'b1;
        enable[EN_MARIN] = 1'b1;
        enable[EN_ZIN]   = 1'b1;
        Control_Signals  = ALU_INCPC;
      end
      ST_T1: begin
        busSelect[BS_ZLO] = 1'b1;
        enable[EN_PCIN]   = 1'b1;
        enable[EN_MDRIN]  = 1'b1;
        MD_Read           = 1'b1;
        ReadRAM           = 1'b1;
      end
      ST_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IRIN]   = 1'b1;
      end
      // IR was loaded on the edge into T3, so op_q is not valid until T4.
      ST_T3: begin
        if (has_exec(ir_op)) begin
          Grb            = 1'b1;
          Rout           = 1'b1;
          BAout          = is_mem_op(ir_op);
          enable[EN_YIN] = 1'b1;
        end
      end
      ST_T4: begin
        if (has_exec(op_q)) begin
          busSelect[BS_CSIGN] = 1'b1;
          enable[EN_ZIN]      = 1'b1;
          Control_Signals     = ALU_ADD;
        end
      end
      ST_T5: begin
        if (is_short_op(op_q)) begin
          busSelect[BS_ZLO] = 1'b1;
          Gra               = 1'b1;
          Rin               = 1'b1;
        end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
          busSelect[BS_ZLO] = 1'b1;
          enable[EN_MARIN]  = 1'b1;
        end
      end
      ST_T6: begin
        if (op_q == OP_LD) begin
          MD_Read          = 1'b1;
          ReadRAM          = 1'b1;
          enable[EN_MDRIN] = 1'b1;
        end else if (op_q == OP_ST) begin
          Gra      = 1'b1;
          BAout    = 1'b1;
          Rout     = 1'b1;
          WriteRAM = 1'b1;
        end
      end
      ST_T7: begin
        if (op_q == OP_LD) begin
          busSelect[BS_MDR] = 1'b1;
          Gra               = 1'b1;
          Rin               = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hard-wired control sequencer: fetch T0-T2, decode/execute T3-T7, HALT.
// Define CTRL_MEM_WAIT_EN to stall T1 and ld-T6 until mem_rdy is high.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic [3:0]  state,
  output logic        halted
);

  state_t  state_q, state_d;
  opcode_t op_q, op_d;
  opcode_t ir_op;
  state_t  after_last;
  logic    mem_ok;

  logic [26:0] unused_ir;
  assign unused_ir = ir[26:0];
  assign ir_op     = ir[31:27];

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ok = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign mem_ok         = 1'b1;
`endif

  assign after_last = run ? ST_T0 : ST_IDLE;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ok) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        op_d = ir_op;
        if (ir_op == OP_HALT)    state_d = ST_HALT;
        else if (has_exec(ir_op)) state_d = ST_T4;
        else                      state_d = after_last;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = is_short_op(op_q) ? after_last : ST_T6;
      ST_T6: begin
        if (op_q == OP_LD) begin
          if (mem_ok) state_d = ST_T7;
        end else begin
          state_d = after_last;
        end
      end
      ST_T7:   state_d = after_last;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign state = state_q;

  ctrl_sequencer_out_decode u_out_decode (
    .state           (state_q),
    .ir_op           (ir_op),
    .op_q            (op_q),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .MD_Read         (MD_Read),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .halted          (halted)
  );

  // The shared bus may have at most one driver in any state.
  a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr)
    ($countones({busSelect, (Rout | BAout)}) <= 1));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; optionally exercises the
// CTRL_MEM_WAIT_EN stall path when that macro is defined.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        MD_Read, ReadRAM, WriteRAM;
  logic [3:0]  state;
  logic        halted;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] IR_LD   = 32'h0008_0055;
  localparam logic [31:0] IR_ST   = 32'h1008_0067;
  localparam logic [31:0] IR_LDI  = 32'h0800_0000;
  localparam logic [31:0] IR_ADDI = 32'h6000_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  ctrl_sequencer dut (
    .clk             (clk),
    .clr             (clr),
    .run             (run),
    .ir              (ir),
    .mem_rdy         (mem_rdy),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .MD_Read         (MD_Read),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .state           (state),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // Observation layout: {state, enable, busSelect, ALU, {Gra,Grb,Grc,Rin,Rout,BAout}, {MD_Read,ReadRAM,WriteRAM}, halted}
  function automatic logic [82:0] snap();
    return {state, enable, busSelect, Control_Signals,
            Gra, Grb, Grc, Rin, Rout, BAout,
            MD_Read, ReadRAM, WriteRAM, halted};
  endfunction

  function automatic logic [82:0] ev(input logic [3:0] st, input logic [31:0] en,
                                     input logic [31:0] bus, input logic [4:0] cs,
                                     input logic [5:0] sel, input logic [2:0] mem,
                                     input logic h);
    return {st, en, bus, cs, sel, mem, h};
  endfunction

  function automatic logic [82:0] v_idle();
    return ev(4'd0, 32'h0, 32'h0, 5'd0, 6'b000000, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t0();
    return ev(4'd1, 32'h0204_0000, 32'h0010_0000, 5'd14, 6'b000000, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t1();
    return ev(4'd2, 32'h0030_0000, 32'h0008_0000, 5'd0, 6'b000000, 3'b110, 1'b0);
  endfunction
  function automatic logic [82:0] v_t2();
    return ev(4'd3, 32'h0100_0000, 32'h0020_0000, 5'd0, 6'b000000, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t3_mem();
    return ev(4'd4, 32'h0008_0000, 32'h0, 5'd0, 6'b010011, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t4();
    return ev(4'd5, 32'h0004_0000, 32'h0080_0000, 5'd1, 6'b000000, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t5_mem();
    return ev(4'd6, 32'h0200_0000, 32'h0008_0000, 5'd0, 6'b000000, 3'b000, 1'b0);
  endfunction
  function automatic logic [82:0] v_t5_short();
    return ev(4'd6, 32'h0, 32'h0008_0000, 5'd0, 6'b100100, 3'b000, 1'b0);
  endfunction

  task automatic do_reset();
    clr = 1'b0;
    run = 1'b0;
    mem_rdy = 1'b1;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (snap() !== v_idle())
      $display("FAIL reset_idle: got %h expected %h", snap(), v_idle());
    if (snap() !== v_idle()) bad++;
    ir = IR_LD;
    clr = 1'b1;
    run = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (snap() !== v_t5_mem()) begin
      bad++;
      $display("FAIL reset_pre_t5: got %h expected %h", snap(), v_t5_mem());
    end
    clr = 1'b0;
    #1;
    total++;
    if (snap() !== v_idle()) begin
      bad++;
      $display("FAIL reset_async_clear: got %h expected %h", snap(), v_idle());
    end
    @(negedge clk);
    total++;
    if (snap() !== v_idle()) begin
      bad++;
      $display("FAIL reset_held: got %h expected %h", snap(), v_idle());
    end
    clr = 1'b1;
    @(negedge clk);
    total++;
    if (snap() !== v_t0()) begin
      bad++;
      $display("FAIL reset_release_t0: got %h expected %h", snap(), v_t0());
    end
  endtask

  task automatic test_ld();
    logic [82:0] exp [9];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = v_t3_mem();
    exp[4] = v_t4();
    exp[5] = v_t5_mem();
    exp[6] = ev(4'd7, 32'h0020_0000, 32'h0, 5'd0, 6'b000000, 3'b110, 1'b0);
    exp[7] = ev(4'd8, 32'h0, 32'h0020_0000, 5'd0, 6'b100100, 3'b000, 1'b0);
    exp[8] = v_t0();
    do_reset();
    ir = IR_LD;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL ld step %0d: got %h expected %h", i, snap(), exp[i]);
      end
      // Later steps must follow the latched opcode, not a changing IR.
      if (i == 4) ir = IR_BAD;
    end
  endtask

  task automatic test_st_run_drop();
    logic [82:0] exp [9];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = v_t3_mem();
    exp[4] = v_t4();
    exp[5] = v_t5_mem();
    exp[6] = ev(4'd7, 32'h0, 32'h0, 5'd0, 6'b100011, 3'b001, 1'b0);
    exp[7] = v_idle();
    exp[8] = v_idle();
    do_reset();
    ir = IR_ST;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL st step %0d: got %h expected %h", i, snap(), exp[i]);
      end
      if (i == 1) run = 1'b0;
    end
  endtask

  task automatic test_addi();
    logic [82:0] exp [7];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = ev(4'd4, 32'h0008_0000, 32'h0, 5'd0, 6'b010010, 3'b000, 1'b0);
    exp[4] = v_t4();
    exp[5] = v_t5_short();
    exp[6] = v_t0();
    do_reset();
    ir = IR_ADDI;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL addi step %0d: got %h expected %h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic test_ldi();
    logic [82:0] exp [7];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = v_t3_mem();
    exp[4] = v_t4();
    exp[5] = v_t5_short();
    exp[6] = v_idle();
    do_reset();
    ir = IR_LDI;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL ldi step %0d: got %h expected %h", i, snap(), exp[i]);
      end
      if (i == 5) run = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [82:0] exp [5];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = ev(4'd4, 32'h0, 32'h0, 5'd0, 6'b000000, 3'b000, 1'b0);
    exp[4] = v_t0();
    do_reset();
    ir = IR_BAD;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL nop step %0d: got %h expected %h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [82:0] exp [7];
    exp[0] = v_t0();
    exp[1] = v_t1();
    exp[2] = v_t2();
    exp[3] = ev(4'd4, 32'h0, 32'h0, 5'd0, 6'b000000, 3'b000, 1'b0);
    exp[4] = ev(4'd15, 32'h0, 32'h0, 5'd0, 6'b000000, 3'b000, 1'b1);
    exp[5] = exp[4];
    exp[6] = exp[4];
    do_reset();
    ir = IR_HALT;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL halt step %0d: got %h expected %h", i, snap(), exp[i]);
      end
      if (i == 4) ir = IR_LD;
    end
    clr = 1'b0;
    #1;
    total++;
    if (snap() !== v_idle()) begin
      bad++;
      $display("FAIL halt_clear: got %h expected %h", snap(), v_idle());
    end
  endtask

`ifdef CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [82:0] exp [7];
    exp[0] = v_t2();
    exp[1] = v_t3_mem();
    exp[2] = v_t4();
    exp[3] = v_t5_mem();
    exp[4] = ev(4'd7, 32'h0020_0000, 32'h0, 5'd0, 6'b000000, 3'b110, 1'b0);
    exp[5] = ev(4'd8, 32'h0, 32'h0020_0000, 5'd0, 6'b100100, 3'b000, 1'b0);
    exp[6] = v_idle();
    do_reset();
    ir = IR_LD;
    run = 1'b1;
    @(negedge clk);
    total++;
    if (snap() !== v_t0()) begin
      bad++;
      $display("FAIL wait_t0: got %h expected %h", snap(), v_t0());
    end
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== v_t1()) begin
        bad++;
        $display("FAIL wait_t1 hold %0d: got %h expected %h", i, snap(), v_t1());
      end
    end
    mem_rdy = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (snap() !== exp[i]) begin
        bad++;
        $display("FAIL wait_ld step %0d: got %h expected %h", i, snap(), exp[i]);
      end
    end
  endtask
`endif

  initial begin
    clr = 1'b0;
    run = 1'b0;
    ir = 32'h0;
    mem_rdy = 1'b1;
    test_reset();
    test_ld();
    test_st_run_drop();
    test_addi();
    test_ldi();
    test_illegal();
    test_halt();
`ifdef CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
